// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S 16-bit processor: decoded instructions, control
// FSM states and ALU operation codes.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_LOAD_1   = 4'd3,
    S_LOAD_2   = 4'd4,
    S_STORE_1  = 4'd5,
    S_STORE_2  = 4'd6,
    S_ALU_1    = 4'd7,
    S_ALU_2    = 4'd8,
    S_BRANCH_1 = 4'd9,
    S_HALT     = 4'd10
  } ctrl_state_type;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the K&S processor: fetch, decode and execute sequencing
// of the datapath enables, ALU op, memory write strobe and halt.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | post-reset, nothing driven
// FETCH      | RAM addressed by PC, IR loads
// DECODE     | PC increments, dispatch on decoded instruction
// LOAD_1/2   | RAM addressed by IR field; LOAD_2 writes data_in to reg
// STORE_1/2  | RAM addressed by IR field; STORE_2 strobes the RAM write
// ALU_1/2    | operands settle; ALU_2 commits result (and flags)
// BRANCH_1   | PC loads IR address when the condition holds
// HALT       | stopped until reset
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  ctrl_state_type state, next_state;
  logic           cond;
  logic [1:0]     alu_op;

  // No branch tests the signed overflow flag; it is kept on the port for the datapath pairing.
  logic unused_signed_overflow;
  assign unused_signed_overflow = signed_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    cond = 1'b0;
    case (decoded_instruction)
      I_BRANCH: cond = 1'b1;
      I_BZERO:  cond = zero_op;
      I_BNZERO: cond = !zero_op;
      I_BNEG:   cond = neg_op;
      I_BNNEG:  cond = !neg_op;
      I_BOV:    cond = unsigned_overflow;
      I_BNOV:   cond = !unsigned_overflow;
      default:  cond = 1'b0;
    endcase
  end

  // MOVE uses AND: the source is routed to both ALU ports and passes through.
  always_comb begin
    alu_op = OP_ADD;
    case (decoded_instruction)
      I_ADD:   alu_op = OP_ADD;
      I_SUB:   alu_op = OP_SUB;
      I_AND:   alu_op = OP_AND;
      I_OR:    alu_op = OP_OR;
      I_MOVE:  alu_op = OP_AND;
      default: alu_op = OP_ADD;
    endcase
  end

  always_comb begin
    next_state       = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        ir_enable  = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        pc_enable = 1'b1;
        case (decoded_instruction)
          I_LOAD:                             next_state = S_LOAD_1;
          I_STORE:                            next_state = S_STORE_1;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:  next_state = S_ALU_1;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:             next_state = S_BRANCH_1;
          I_HALT:                             next_state = S_HALT;
          default:                            next_state = S_FETCH;
        endcase
      end
      S_LOAD_1: begin
        addr_sel   = 1'b1;
        next_state = S_LOAD_2;
      end
      S_LOAD_2: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        next_state       = S_FETCH;
      end
      S_STORE_1: begin
        addr_sel   = 1'b1;
        next_state = S_STORE_2;
      end
      S_STORE_2: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        next_state       = S_FETCH;
      end
      S_ALU_1: begin
        operation  = alu_op;
        next_state = S_ALU_2;
      end
      S_ALU_2: begin
        operation        = alu_op;
        write_reg_enable = 1'b1;
        flags_reg_enable = (decoded_instruction != I_MOVE);
        next_state       = S_FETCH;
      end
      S_BRANCH_1: begin
        pc_enable  = cond;
        branch     = cond;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halt       = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven instruction stream with a
// per-cycle expected-output scoreboard, plus halt and mid-instruction reset sequences.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt)
  );

  always #5 clk = ~clk;

  // {halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0], wre, fre, rwe}
  logic [10:0] act;
  assign act = {halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable};

  function automatic logic [10:0] ow(logic h, logic br, logic pc, logic ir, logic as,
                                     logic cs, logic [1:0] op, logic wr, logic fl, logic rw);
    return {h, br, pc, ir, as, cs, op, wr, fl, rw};
  endfunction

  localparam logic [10:0] W_ZERO  = 11'd0;
  localparam logic [10:0] W_FETCH = 11'b000_1000_0000;
  localparam logic [10:0] W_DEC   = 11'b001_0000_0000;
  localparam logic [10:0] W_HALT  = 11'b100_0000_0000;

  typedef struct {
    string                   name;
    decoded_instruction_type instr;
    logic                    z, n, uo, so;
    int                      n_exec;
    logic [10:0]             e0, e1;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(string name, logic [10:0] a, logic [10:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  task automatic push(string name, logic [10:0] e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb.push_back(s);
  endtask

  // One scoreboard entry per clock: sample on negedge, advance inputs just after posedge.
  task automatic drain();
    sb_t s;
    while (sb.size() > 0) begin
      @(negedge clk);
      s = sb.pop_front();
      check(s.name, act, s.exp);
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vt[$];

  task automatic add_vec(string name, decoded_instruction_type i, logic z, logic n, logic uo,
                         logic so, int ne, logic [10:0] e0, logic [10:0] e1);
    vec_t v;
    v.name = name; v.instr = i; v.z = z; v.n = n; v.uo = uo; v.so = so;
    v.n_exec = ne; v.e0 = e0; v.e1 = e1;
    vt.push_back(v);
  endtask

  function automatic logic [10:0] w_br(logic c);
    return ow(0, c, c, 0, 0, 0, 2'b00, 0, 0, 0);
  endfunction

  initial begin
    decoded_instruction = I_NOP;
    zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;
    rst_n = 1'b0;

    add_vec("load",    I_LOAD,  0,0,0,0, 2, ow(0,0,0,0,1,0,2'b00,0,0,0), ow(0,0,0,0,1,1,2'b00,1,0,0));
    add_vec("store",   I_STORE, 0,0,0,0, 2, ow(0,0,0,0,1,0,2'b00,0,0,0), ow(0,0,0,0,1,0,2'b00,0,0,1));
    add_vec("add",     I_ADD,   0,0,0,0, 2, ow(0,0,0,0,0,0,2'b00,0,0,0), ow(0,0,0,0,0,0,2'b00,1,1,0));
    add_vec("sub",     I_SUB,   0,0,0,0, 2, ow(0,0,0,0,0,0,2'b11,0,0,0), ow(0,0,0,0,0,0,2'b11,1,1,0));
    add_vec("and",     I_AND,   0,0,0,0, 2, ow(0,0,0,0,0,0,2'b01,0,0,0), ow(0,0,0,0,0,0,2'b01,1,1,0));
    add_vec("or",      I_OR,    0,0,0,0, 2, ow(0,0,0,0,0,0,2'b10,0,0,0), ow(0,0,0,0,0,0,2'b10,1,1,0));
    add_vec("move",    I_MOVE,  1,1,1,1, 2, ow(0,0,0,0,0,0,2'b01,0,0,0), ow(0,0,0,0,0,0,2'b01,1,0,0));
    add_vec("nop",     I_NOP,   0,0,0,0, 0, W_ZERO, W_ZERO);
    add_vec("unrec",   decoded_instruction_type'(5'd31), 1,1,1,1, 0, W_ZERO, W_ZERO);
    add_vec("branch",  I_BRANCH, 0,0,0,0, 1, w_br(1), W_ZERO);
    add_vec("bzero1",  I_BZERO,  1,0,0,0, 1, w_br(1), W_ZERO);
    add_vec("bzero0",  I_BZERO,  0,1,1,1, 1, w_br(0), W_ZERO);
    add_vec("bnzero1", I_BNZERO, 1,0,0,0, 1, w_br(0), W_ZERO);
    add_vec("bnzero0", I_BNZERO, 0,1,1,1, 1, w_br(1), W_ZERO);
    add_vec("bneg1",   I_BNEG,   0,1,0,0, 1, w_br(1), W_ZERO);
    add_vec("bneg0",   I_BNEG,   1,0,1,1, 1, w_br(0), W_ZERO);
    add_vec("bnneg1",  I_BNNEG,  0,1,0,0, 1, w_br(0), W_ZERO);
    add_vec("bnneg0",  I_BNNEG,  1,0,1,1, 1, w_br(1), W_ZERO);
    add_vec("bov1",    I_BOV,    0,0,1,0, 1, w_br(1), W_ZERO);
    add_vec("bov0",    I_BOV,    1,1,0,1, 1, w_br(0), W_ZERO);
    add_vec("bnov1",   I_BNOV,   0,0,1,0, 1, w_br(0), W_ZERO);
    add_vec("bnov0",   I_BNOV,   1,1,0,1, 1, w_br(1), W_ZERO);

    // Outputs stay 0 throughout reset.
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", act, W_ZERO);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("idle", W_ZERO);
    drain();

    foreach (vt[k]) begin
      decoded_instruction = vt[k].instr;
      zero_op = vt[k].z; neg_op = vt[k].n;
      unsigned_overflow = vt[k].uo; signed_overflow = vt[k].so;
      push({vt[k].name, "_fetch"}, W_FETCH);
      push({vt[k].name, "_decode"}, W_DEC);
      if (vt[k].n_exec > 0) push({vt[k].name, "_exec1"}, vt[k].e0);
      if (vt[k].n_exec > 1) push({vt[k].name, "_exec2"}, vt[k].e1);
      drain();
    end

    // HALT: held while inputs toggle.
    decoded_instruction = I_HALT;
    push("halt_fetch", W_FETCH);
    push("halt_decode", W_DEC);
    drain();
    for (int c = 0; c < 22; c++) begin
      push("halt_hold", W_HALT);
      drain();
      decoded_instruction = decoded_instruction_type'(5'($urandom_range(0, 31)));
      {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'($urandom_range(0, 15));
    end
    #2 rst_n = 1'b0;
    #1 check("halt_reset_async", act, W_ZERO);
    @(posedge clk);
    #1 rst_n = 1'b1;
    decoded_instruction = I_NOP;
    push("halt_rel_idle", W_ZERO);
    push("halt_rel_fetch", W_FETCH);
    drain();

    // Reset during ALU_2: write and flag strobes drop on the rst_n edge.
    decoded_instruction = I_ADD;
    push("ar_decode", W_DEC);
    push("ar_alu1", W_ZERO);
    drain();
    check("ar_alu2", act, ow(0,0,0,0,0,0,2'b00,1,1,0));
    rst_n = 1'b0;
    #1 check("ar_async", act, W_ZERO);
    @(posedge clk);
    #1 check("ar_held", act, W_ZERO);
    rst_n = 1'b1;
    decoded_instruction = I_STORE;
    push("ar_rel_idle", W_ZERO);
    push("ar_rel_fetch", W_FETCH);
    push("sr_decode", W_DEC);
    push("sr_store1", ow(0,0,0,0,1,0,2'b00,0,0,0));
    drain();

    // Reset during STORE_2.
    check("sr_store2", act, ow(0,0,0,0,1,0,2'b00,0,0,1));
    rst_n = 1'b0;
    #1 check("sr_async", act, W_ZERO);
    @(posedge clk);
    #1 rst_n = 1'b1;
    decoded_instruction = I_NOP;
    push("sr_rel_idle", W_ZERO);
    push("sr_rel_fetch", W_FETCH);
    push("sr_rel_decode", W_DEC);
    push("sr_rel_fetch2", W_FETCH);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style control FSM for the K&S 16-bit processor, paired with `data_path` inside the CPU top level. It consumes the decoded instruction and the registered ALU flags, and sequences every instruction through fetch, decode and execute. It drives the datapath enables, the ALU operation, the memory write strobe and a halt indication. Memory is asynchronous-read: `data_in` is valid in the same cycle `ram_addr` is presented.

## Interface
No parameters.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- decoded_instruction  in  decoded_instruction_type  current IR contents, decoded by the datapath.
- zero_op, neg_op  in  1 each  registered zero/negative flags.
- unsigned_overflow, signed_overflow  in  1 each  registered carry-out/signed overflow flags.
- branch  out  1  PC load source: 1 = IR address, 0 = PC+1.
- pc_enable  out  1  PC update strobe.
- ir_enable  out  1  IR load strobe.
- addr_sel  out  1  RAM address mux: 0 = PC, 1 = IR address field.
- c_sel  out  1  register write mux: 0 = ALU, 1 = data_in.
- operation  out  2  ALU op: 00 add, 01 and, 10 or, 11 sub.
- write_reg_enable  out  1  register-file write strobe.
- flags_reg_enable  out  1  flag register update strobe.
- ram_write_enable  out  1  memory write strobe; data_out is written to ram_addr.
- halt  out  1  processor stopped.

## Operation
- States: IDLE, FETCH, DECODE, LOAD_1, LOAD_2, STORE_1, STORE_2, ALU_1, ALU_2, BRANCH_1, HALT.
- All outputs are a pure function of the state, except `pc_enable`/`branch` in BRANCH_1. Unlisted outputs are 0.
- IDLE: all 0. Always goes to FETCH.
- FETCH: addr_sel=0, ir_enable=1. Goes to DECODE.
- DECODE: pc_enable=1, branch=0, so PC increments. Next state by decoded_instruction:
  - LOAD → LOAD_1; STORE → STORE_1.
  - MOVE/ADD/SUB/AND/OR → ALU_1.
  - any branch → BRANCH_1; HALT → HALT.
  - NOP or unrecognised → FETCH.
- LOAD_1: addr_sel=1. LOAD_2: addr_sel=1, c_sel=1, write_reg_enable=1.
- STORE_1: addr_sel=1. STORE_2: addr_sel=1, ram_write_enable=1.
- ALU_1 and ALU_2 both drive the same operation code:
  - ADD=00, AND=01, OR=10, SUB=11.
  - MOVE=01: source reaches both ALU ports, so AND passes it through.
- ALU_2 also drives write_reg_enable=1. It drives flags_reg_enable=1 for all ALU ops except MOVE, which leaves the flags unchanged.
- BRANCH_1: addr_sel=0. pc_enable=branch=cond, where cond is:
  - BRANCH: 1.
  - BZERO / BNZERO: zero_op / !zero_op.
  - BNEG / BNNEG: neg_op / !neg_op.
  - BOV / BNOV: unsigned_overflow / !unsigned_overflow.
- LOAD_2, STORE_2, ALU_2 and BRANCH_1 all return to FETCH.
- HALT: halt=1, all other outputs 0. The FSM stays in HALT until rst_n is asserted.

## Timing
- Reset: state=IDLE and every output is 0 while rst_n=0. The first FETCH occurs in the cycle after rst_n deasserts.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe may remain asserted after the rst_n falling edge.
- Cycles per instruction, counted from FETCH:
  - NOP: 2.
  - Branch, taken or not: 3.
  - LOAD, STORE, MOVE, ALU ops: 4.
  - HALT: 2 cycles to reach the HALT state.
- Flags are evaluated in BRANCH_1 from their registered values. They therefore reflect the most recent ALU op that updated them, including one immediately preceding the branch.
- ALU_1 exists so that registered operand reads settle before ALU_2 commits the result. ram_write_enable in STORE_2 has the same purpose.
- Write strobes (write_reg_enable, ram_write_enable, flags_reg_enable) are asserted for exactly one cycle per instruction.

## Structure
- `k_and_s_pkg` holds `decoded_instruction_type` (already shared).
- Add to `k_and_s_pkg`: `ctrl_state_type` enum, and ALU op constants `OP_ADD`, `OP_AND`, `OP_OR`, `OP_SUB`.
- Single module, no sub-modules. Use a state register plus a combinational next-state/output block. Branch condition evaluation is an inline case.

## Test plan
- Reset, then release: outputs all 0 during reset; IDLE→FETCH (ir_enable=1, addr_sel=0)→DECODE (pc_enable=1, branch=0).
- ADD stream: decoded_instruction=I_ADD → ALU_1 then ALU_2 with operation=00, write_reg_enable=1, flags_reg_enable=1 for 1 cycle; SUB gives operation=11; MOVE gives operation=01, flags_reg_enable=0.
- LOAD: LOAD_2 shows addr_sel=1, c_sel=1, write_reg_enable=1. STORE: STORE_2 shows addr_sel=1, ram_write_enable=1, write_reg_enable=0.
- Conditional branches: BZERO with zero_op=1 gives pc_enable=1, branch=1; with zero_op=0 gives pc_enable=0. Repeat for all six conditionals, both flag values.
- HALT: halt=1 held for 20+ cycles with all strobes 0 while inputs toggle; rst_n pulse returns to IDLE, halt=0.
- Reset asserted during ALU_2 and STORE_2: strobes drop asynchronously; the next fetch follows release.
